// File: rtl/intpol2_d4_out_drain_pkg.sv
// rtl/intpol2_d4_out_drain_pkg.sv - shared state encoding, default widths and skid room check
package intpol2_d4_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } drain_state_e;

  // Occupancy is taken after this cycle's pop so reads can issue back-to-back at full rate.
  function automatic logic read_room(input logic [1:0] occ, input logic pop, input logic inflight);
    logic [2:0] total;
    total = {1'b0, occ} - {2'b00, pop} + {2'b00, inflight};
    return total < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/intpol2_d4_out_drain_if.sv
// rtl/intpol2_d4_out_drain_if.sv - FIFO read port and downstream valid/ready stream
interface intpol2_d4_out_drain_if
  import intpol2_d4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_re;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_re, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_re, m_valid, m_data
  );
endinterface

// File: rtl/intpol2_d4_out_drain_skid2.sv
// rtl/intpol2_d4_out_drain_skid2.sv - two-entry shifting skid buffer, head always in entry 0
module intpol2_d4_skid2
  import intpol2_d4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);
  logic [DATA_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = push_data;
          else               ent1_d = push_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_d = push_data;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign head  = ent0_q;
  assign occ   = cnt_q;
endmodule

// File: rtl/intpol2_d4_out_drain.sv
// rtl/intpol2_d4_out_drain.sv - drains the output-sample FIFO into a valid/ready stream,
// in fixed-length blocks or as a stoppable continuous stream.
module intpol2_d4_out_drain
  import intpol2_d4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   stop,
  input  logic [CNT_W-1:0]       len,
  intpol2_d4_out_drain_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   clear,
  output logic [CNT_W-1:0]       sample_cnt
);
  drain_state_e      state_q, state_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              inflight_q, inflight_d;
  logic              busy_q, busy_d, done_q, done_d, clear_q, clear_d;
  logic              fifo_re, pop, buf_valid, buf_empty, flush;
  logic [1:0]        occ;
  logic [DATA_W-1:0] head;

  intpol2_d4_skid2 #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (inflight_q),
    .push_data (bus.fifo_rdata),
    .pop       (pop),
    .valid     (buf_valid),
    .head      (head),
    .occ       (occ)
  );

  always_comb begin
    pop       = buf_valid && bus.m_ready;
    buf_empty = (occ == 2'd0) && !inflight_q;
    fifo_re   = !rst && !start && (state_q == S_RUN) && !bus.fifo_empty
                && read_room(occ, pop, inflight_q) && (mode_q || (rd_cnt_q < len_q));

    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    case (state_q)
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (mode_q) begin
          if (stop) state_d = S_FLUSH;
        end else if ((sample_cnt_q == len_q) && buf_empty) begin
          state_d = S_DONE;
        end
      end
      S_FLUSH: if (buf_empty) state_d = S_DONE;
      S_DONE:  state_d = IDLE;
      default: state_d = state_q;
    endcase
    // Abort/restart outranks every other transition, including a run's final beat.
    if (start) begin
      state_d = S_CLEAR;
      mode_d  = mode;
      len_d   = len;
    end

    flush        = (state_d == S_CLEAR);
    inflight_d   = fifo_re;
    rd_cnt_d     = flush ? '0 : rd_cnt_q + CNT_W'(fifo_re);
    sample_cnt_d = flush ? '0 : sample_cnt_q + CNT_W'(pop);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == S_DONE);
    clear_d      = flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      len_q        <= '0;
      sample_cnt_q <= '0;
      rd_cnt_q     <= '0;
      inflight_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      len_q        <= len_d;
      sample_cnt_q <= sample_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      inflight_q   <= inflight_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      clear_q      <= clear_d;
    end
  end

  assign bus.fifo_re = fifo_re;
  assign bus.m_valid = buf_valid;
  assign bus.m_data  = head;
  assign busy        = busy_q;
  assign done        = done_q;
  assign clear       = clear_q;
  assign sample_cnt  = sample_cnt_q;
endmodule

// File: tb/tb_intpol2_d4_out_drain.sv
// tb/tb_intpol2_d4_out_drain.sv - scoreboard bench for the output drain
module tb_intpol2_d4_out_drain;
  logic        clk = 1'b0;
  logic        rst, start, mode, stop;
  logic [15:0] len;
  logic        busy, done, clear;
  logic [15:0] sample_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  intpol2_d4_out_drain_if #(.DATA_W(32)) bus ();

  intpol2_d4_out_drain #(.DATA_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .stop       (stop),
    .len        (len),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .clear      (clear),
    .sample_cnt (sample_cnt)
  );

  // FIFO model: data appears on fifo_rdata the cycle after fifo_re
  logic [31:0] fifo_mem [0:255];
  int          fifo_wr = 0;
  int          fifo_rd = 0;
  logic        fifo_flush = 1'b0;

  assign bus.fifo_empty = (fifo_wr == fifo_rd);

  always @(posedge clk) begin
    if (fifo_flush) begin
      fifo_rd <= fifo_wr;
    end else if (bus.fifo_re && (fifo_wr != fifo_rd)) begin
      bus.fifo_rdata <= fifo_mem[fifo_rd % 256];
      fifo_rd        <= fifo_rd + 1;
    end
  end

  // Scoreboard monitor
  logic [31:0] exp_q [$];
  int          hs_cyc [$];
  int          beat_cnt = 0;
  int          done_cnt = 0;
  int          re_cnt   = 0;
  int          viol     = 0;
  int          cyc      = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (bus.fifo_re) re_cnt++;
        if (bus.fifo_re && bus.fifo_empty) viol++;
        if (prev_stall && !clear) begin
          total++;
          if (!bus.m_valid || (bus.m_data !== prev_data)) begin
            bad++;
            $display("FAIL stall_hold: got valid=%0b data=%0h want valid=1 data=%0h",
                     bus.m_valid, bus.m_data, prev_data);
          end
        end
        if (bus.m_valid && bus.m_ready) begin
          beat_cnt++;
          hs_cyc.push_back(cyc);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: got data=%0h want no beat", bus.m_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.m_data !== e) begin
              bad++;
              $display("FAIL beat_data: got %0h want %0h", bus.m_data, e);
            end
          end
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input bit expect_it);
    fifo_mem[fifo_wr % 256] = d;
    fifo_wr++;
    if (expect_it) exp_q.push_back(d);
  endtask

  task automatic go(input logic m, input logic [15:0] l);
    mode  = m;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, input bit toggle);
    int d0 = done_cnt;
    int i  = 0;
    while ((done_cnt == d0) && (i < limit)) begin
      if (toggle) bus.m_ready = ~bus.m_ready;
      tick();
      i++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s_timeout: got no done after %0d cycles want done", name, limit);
    end
  endtask

  task automatic wait_beats(input string name, input int n, input int limit);
    int b0 = beat_cnt;
    int i  = 0;
    while ((beat_cnt - b0 < n) && (i < limit)) begin
      tick();
      i++;
    end
    total++;
    if (beat_cnt - b0 < n) begin
      bad++;
      $display("FAIL %s_timeout: got %0d beats want %0d", name, beat_cnt - b0, n);
    end
  endtask

  initial begin
    int r0, b0, d0, k;
    rst = 1'b1; start = 1'b0; mode = 1'b0; stop = 1'b0; len = '0;
    bus.m_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_fifo_re", bus.fifo_re, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_clear", clear, 0);
    chk("rst_sample_cnt", sample_cnt, 0);

    // Block run of 8 at full rate
    for (int i = 0; i < 8; i++) push(32'h100 + i, 1'b1);
    bus.m_ready = 1'b1;
    r0 = re_cnt; b0 = beat_cnt; d0 = done_cnt;
    hs_cyc.delete();
    go(1'b0, 16'd8);
    chk("t1_clear", clear, 1);
    chk("t1_busy", busy, 1);
    wait_done("t1", 60, 1'b0);
    chk("t1_busy_after", busy, 0);
    chk("t1_cnt", sample_cnt, 8);
    chk("t1_reads", re_cnt - r0, 8);
    chk("t1_beats", beat_cnt - b0, 8);
    if (hs_cyc.size() >= 8) chk("t1_consecutive", hs_cyc[7] - hs_cyc[0], 7);
    repeat (3) tick();
    chk("t1_done_pulses", done_cnt - d0, 1);

    // Backpressure with len=4 while the FIFO holds 6
    for (int i = 0; i < 6; i++) push(32'h200 + i, i < 4);
    r0 = re_cnt; b0 = beat_cnt;
    bus.m_ready = 1'b1;
    go(1'b0, 16'd4);
    wait_done("t2", 80, 1'b1);
    chk("t2_reads", re_cnt - r0, 4);
    chk("t2_beats", beat_cnt - b0, 4);
    chk("t2_cnt", sample_cnt, 4);
    fifo_flush = 1'b1; tick(); fifo_flush = 1'b0;

    // Sparse FIFO: one sample every third cycle
    bus.m_ready = 1'b1;
    d0 = done_cnt; b0 = beat_cnt; k = 0;
    go(1'b0, 16'd6);
    for (int i = 0; (i < 200) && (done_cnt == d0); i++) begin
      if ((k < 6) && (i % 3 == 0)) begin
        push(32'h300 + k, 1'b1);
        k++;
      end
      tick();
    end
    chk("t3_done_seen", done_cnt - d0, 1);
    chk("t3_beats", beat_cnt - b0, 6);
    chk("t3_no_read_empty", viol, 0);

    // Stream mode, stop with two samples held back
    for (int i = 0; i < 20; i++) push(32'h400 + i, i < 7);
    b0 = beat_cnt; d0 = done_cnt;
    bus.m_ready = 1'b1;
    go(1'b1, 16'd3);
    wait_beats("t4_five", 5, 60);
    bus.m_ready = 1'b0;
    repeat (3) tick();
    chk("t4_buffered", bus.m_valid, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    bus.m_ready = 1'b1;
    wait_done("t4", 40, 1'b0);
    repeat (3) tick();
    chk("t4_beats", beat_cnt - b0, 7);
    chk("t4_done_pulses", done_cnt - d0, 1);
    fifo_flush = 1'b1; tick(); fifo_flush = 1'b0;

    // Abort after three beats, restart with fresh data
    for (int i = 0; i < 8; i++) push(32'h500 + i, i < 3);
    d0 = done_cnt;
    bus.m_ready = 1'b1;
    go(1'b0, 16'd8);
    wait_beats("t5_three", 3, 60);
    bus.m_ready = 1'b0;
    mode = 1'b0; len = 16'd4; start = 1'b1; fifo_flush = 1'b1;
    tick();
    start = 1'b0; fifo_flush = 1'b0;
    chk("t5_clear", clear, 1);
    chk("t5_cnt_zero", sample_cnt, 0);
    chk("t5_flushed", bus.m_valid, 0);
    for (int i = 0; i < 4; i++) push(32'h600 + i, 1'b1);
    bus.m_ready = 1'b1;
    wait_done("t5", 60, 1'b0);
    repeat (3) tick();
    chk("t5_done_pulses", done_cnt - d0, 1);
    chk("t5_cnt", sample_cnt, 4);
    chk("t5_exp_empty", exp_q.size(), 0);

    // len=0: done two cycles after start, no reads
    r0 = re_cnt;
    go(1'b0, 16'd0);
    chk("t6_clear", clear, 1);
    tick();
    chk("t6_done_early", done, 0);
    tick();
    chk("t6_done", done, 1);
    tick();
    chk("t6_busy_after", busy, 0);
    chk("t6_reads", re_cnt - r0, 0);

    // Reset in the middle of a run
    for (int i = 0; i < 8; i++) push(32'h700 + i, i < 2);
    bus.m_ready = 1'b1;
    go(1'b0, 16'd8);
    wait_beats("t7_two", 2, 60);
    bus.m_ready = 1'b0;
    repeat (3) tick();
    chk("t7_pre_cnt", sample_cnt, 2);
    chk("t7_pre_valid", bus.m_valid, 1);
    rst = 1'b1;
    tick();
    chk("t7_fifo_re", bus.fifo_re, 0);
    chk("t7_m_valid", bus.m_valid, 0);
    chk("t7_m_data", bus.m_data, 0);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_clear", clear, 0);
    chk("t7_cnt", sample_cnt, 0);
    rst = 1'b0;
    fifo_flush = 1'b1;
    bus.m_ready = 1'b1;
    tick();
    fifo_flush = 1'b0;
    repeat (4) tick();
    chk("t7_no_capture", bus.m_valid, 0);
    chk("t7_idle", busy, 0);

    chk("all_no_read_empty", viol, 0);
    chk("all_exp_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/intpol2_d4_out_drain.md
INTPOL2_D4_OUT_DRAIN -- requirements
Module: intpol2_D4_out_drain

Interface
REQ-001 SHALL have parameter DATA_W, default 32, output sample width.
REQ-002 SHALL have parameter CNT_W, default 16, sample counter width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  begin, or abort and restart, a drain run.
REQ-006 SHALL have port mode  input  1  0 = block of len samples, 1 = continuous stream; sampled at run start.
REQ-007 SHALL have port stop  input  1  stream-mode end request; ignored in block mode.
REQ-008 SHALL have port len  input  CNT_W  block length; sampled at run start.
REQ-009 SHALL have port fifo_empty  input  1  output-sample FIFO empty flag.
REQ-010 SHALL have port fifo_rdata  input  DATA_W  FIFO read data, valid one cycle after fifo_re.
REQ-011 SHALL have port fifo_re  output  1  FIFO read strobe.
REQ-012 SHALL have port m_valid / m_ready / m_data  out/in/out  1/1/DATA_W  downstream valid-ready stream.
REQ-013 SHALL have port busy, done, clear  output  1 each  run active; end-of-run pulse; restart pulse.
REQ-014 SHALL have port sample_cnt  output  CNT_W  samples delivered in the current run.

Function
REQ-015 SHALL implement states IDLE, S_CLEAR, S_RUN, S_FLUSH, S_DONE.
REQ-016 IDLE: start -> S_CLEAR; latch mode and len.
REQ-017 S_CLEAR: clear=1 each cycle; empty the skid buffer, discard in-flight read data, zero sample_cnt; hold while start=1, else -> S_RUN.
REQ-018 Any non-IDLE state with start=1 -> S_CLEAR next cycle. This abort SHALL take precedence over every other transition.
REQ-019 S_RUN: fifo_re = !fifo_empty && (occupancy + inflight < 2) && reads issued < len (block mode). The reads-issued limit SHALL NOT apply in stream mode.
REQ-020 The skid buffer SHALL hold 2 entries and capture fifo_rdata the cycle after fifo_re. It SHALL sustain 1 sample/cycle when m_ready=1 continuously.
REQ-021 m_valid=1 iff buffer non-empty. m_data = head entry, held stable while m_valid && !m_ready.
REQ-022 Each m_valid && m_ready SHALL increment sample_cnt. The counter SHALL wrap modulo 2^CNT_W in stream mode.
REQ-023 Block mode: when sample_cnt reaches len with the buffer empty -> S_DONE.
REQ-024 Block mode, len=0: S_RUN -> S_DONE in the first cycle, with no fifo_re.
REQ-025 Stream mode: stop=1 in S_RUN -> S_FLUSH.
REQ-026 S_FLUSH: no new fifo_re; drain buffered and in-flight samples; when empty -> S_DONE.
REQ-027 S_DONE: done=1 for exactly one cycle -> IDLE.
REQ-028 busy=1 in every state except IDLE.
REQ-029 Simultaneous start and stop: start SHALL win.
REQ-030 Simultaneous final handshake and start: abort SHALL win and no done SHALL be generated.
REQ-031 fifo_re SHALL never assert while fifo_empty=1, or in IDLE, S_CLEAR, S_FLUSH or S_DONE.

Reset
REQ-032 rst=1 at a clk edge -> state IDLE, buffer empty, in-flight flag 0.
REQ-033 Reset values: fifo_re=0, m_valid=0, m_data=0, busy=0, done=0, clear=0, sample_cnt=0.
REQ-034 rst SHALL override start and all other inputs, including mid-run.
REQ-035 No FIFO data arriving after reset SHALL be captured.

Structure
REQ-036 State encodings and default widths SHALL live in the shared package intpol2_D4_pkg.
REQ-037 The 2-entry skid buffer SHALL be a sub-module intpol2_D4_skid2; FSM and counters remain in the top module.

Verification
REQ-038 Block run: mode=0, len=8, FIFO holds 8 samples, m_ready=1 -> 8 beats on consecutive cycles, sample_cnt=8, one done pulse, busy falls after.
REQ-039 Backpressure: len=4, m_ready toggles 1/0 -> m_data stable during stalls, no FIFO overread (exactly 4 fifo_re), data order preserved.
REQ-040 Empty gaps: FIFO refilled every 3rd cycle -> fifo_re never asserts with fifo_empty=1; all samples delivered in order.
REQ-041 Stream stop: mode=1, stop asserted after 5 beats with 2 samples buffered/in flight -> exactly 7 beats, then done.
REQ-042 Abort: start re-asserted mid-run after 3 of 8 beats -> clear pulse, buffer flushed, sample_cnt=0, new run delivers fresh samples, no stale data and no done for the aborted run.
REQ-043 Edge cases: len=0 -> done 2 cycles after start with no fifo_re; rst mid-run -> all outputs at reset values next cycle.
